// File: rtl/d16_pkg.sv
// d16_pkg -- constants shared by the d16 ALU and its writeback stage.
//
// Contents:
//   ALU opcodes     ALU_NOP .. ALU_EQ (3 bits)
//   condition codes COND_AL .. COND_NV (3 bits)
//   flag indices    FLAG_N/O/Z/C into the 4-bit status register {n,o,z,c}
//   op_sets_flags() true for the arithmetic/shift ops that write the status register
package d16_pkg;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_SHL = 3'b011;
  localparam logic [2:0] ALU_SHR = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_AND = 3'b110;
  localparam logic [2:0] ALU_EQ  = 3'b111;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_Z  = 3'b001;
  localparam logic [2:0] COND_NZ = 3'b010;
  localparam logic [2:0] COND_C  = 3'b011;
  localparam logic [2:0] COND_NC = 3'b100;
  localparam logic [2:0] COND_N  = 3'b101;
  localparam logic [2:0] COND_O  = 3'b110;
  localparam logic [2:0] COND_NV = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_O = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  // Only add, sub, shl and shr produce meaningful flags; logic ops and NOP
  // must leave the status register alone.
  function automatic logic op_sets_flags(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SHL) || (op == ALU_SHR);
  endfunction

endpackage

// File: rtl/d16_alu_wb_if.sv
// d16_alu_wb_if -- bus between the d16 ALU, the writeback stage and the
// register-file write port.
//
// ALU side:       in_valid, in_ready, ctrl_alu, s, n, o, z, c, wr_en, rd
// Writeback side: wb_valid, wb_ready, wb_addr, wb_data
// Modports:       master = environment (ALU + register file), slave = writeback stage
interface d16_alu_wb_if #(parameter int REG_AW = 3);

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        ctrl_alu;
  logic [15:0]       s;
  logic              n;
  logic              o;
  logic              z;
  logic              c;
  logic              wr_en;
  logic [REG_AW-1:0] rd;

  logic              wb_valid;
  logic              wb_ready;
  logic [REG_AW-1:0] wb_addr;
  logic [15:0]       wb_data;

  modport master (
    output in_valid, ctrl_alu, s, n, o, z, c, wr_en, rd, wb_ready,
    input  in_ready, wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  in_valid, ctrl_alu, s, n, o, z, c, wr_en, rd, wb_ready,
    output in_ready, wb_valid, wb_addr, wb_data
  );

endinterface

// File: rtl/d16_skid_buf.sv
// d16_skid_buf -- writeback queue between the ALU and the register file.
//
// Build option: D16_WB_SKID_EN
//   defined   -> two-entry skid buffer, registered space (no wb_ready -> in_ready path)
//   undefined -> single entry, space = ~pop_valid | pop_ready (combinational)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   push, push_data       enqueue an entry (caller guarantees space)
//   space                 an entry may be pushed this cycle
//   pop_valid, pop_ready  head entry handshake, pop_data is the head entry
module d16_skid_buf #(parameter int W = 19) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         space,
  input  logic         pop_ready,
  output logic         pop_valid,
  output logic [W-1:0] pop_data
);

`ifdef D16_WB_SKID_EN

  logic [1:0]   count;
  logic [1:0]   count_next;
  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         ready_q;
  logic         pop;

  assign pop       = (count != 2'd0) && pop_ready;
  assign pop_valid = (count != 2'd0);
  assign pop_data  = head;
  assign space     = ready_q;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // head is always the oldest entry; tail only holds data while two are
  // queued. ready_q looks at the post-update occupancy so upstream sees
  // a registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= 2'd0;
      head    <= '0;
      tail    <= '0;
      ready_q <= 1'b1;
    end else begin
      count   <= count_next;
      ready_q <= (count_next < 2'd2);
      if (pop) begin
        if (count == 2'd2) begin
          head <= tail;
          if (push) tail <= push_data;
        end else if (push) begin
          head <= push_data;
        end
      end else if (push) begin
        if (count == 2'd0) head <= push_data;
        else               tail <= push_data;
      end
    end
  end

`else

  logic         valid_q;
  logic [W-1:0] data_q;

  assign pop_valid = valid_q;
  assign pop_data  = data_q;
  // A draining entry frees its slot in the same cycle.
  assign space     = ~valid_q | pop_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (push) begin
      valid_q <= 1'b1;
      data_q  <= push_data;
    end else if (valid_q && pop_ready) begin
      valid_q <= 1'b0;
    end
  end

`endif

endmodule

// File: rtl/d16_alu_wb.sv
// d16_alu_wb -- writeback stage behind the d16 ALU.
//
// Captures the ALU result and flags on accept, keeps the architectural
// status register, queues register-file writes and evaluates branch
// conditions against the status register.
//
// Build option: D16_WB_SKID_EN (see d16_skid_buf) selects queue depth 2.
//
// Ports:
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   bus                 d16_alu_wb_if.slave: ALU handshake + register-file write port
//   flags               status register {n,o,z,c}
//   cond, cond_true     branch condition code and its evaluation on flags
module d16_alu_wb
  import d16_pkg::*;
#(
  parameter int REG_AW = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  d16_alu_wb_if.slave      bus,
  output logic [3:0]       flags,
  input  logic [2:0]       cond,
  output logic             cond_true
);

  logic               space;
  logic               accept;
  logic               push;
  logic [REG_AW+15:0] head;

  assign accept       = bus.in_valid & space;
  assign push         = accept & bus.wr_en;
  assign bus.in_ready = space;
  assign bus.wb_addr  = head[REG_AW+15:16];
  assign bus.wb_data  = head[15:0];

  d16_skid_buf #(.W(REG_AW + 16)) u_queue (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .push      (push),
    .push_data ({bus.rd, bus.s}),
    .space     (space),
    .pop_ready (bus.wb_ready),
    .pop_valid (bus.wb_valid),
    .pop_data  (head)
  );

  // Flags follow program order: they update when the op is accepted, not
  // when its result drains, and ops with wr_en=0 still update them.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      flags <= 4'b0000;
    end else if (accept && op_sets_flags(bus.ctrl_alu)) begin
      flags <= {bus.n, bus.o, bus.z, bus.c};
    end
  end

  // Evaluated on the registered flags only, so an update accepted this
  // cycle is not visible until the next one.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_AL: cond_true = 1'b1;
      COND_Z:  cond_true = flags[FLAG_Z];
      COND_NZ: cond_true = ~flags[FLAG_Z];
      COND_C:  cond_true = flags[FLAG_C];
      COND_NC: cond_true = ~flags[FLAG_C];
      COND_N:  cond_true = flags[FLAG_N];
      COND_O:  cond_true = flags[FLAG_O];
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_d16_alu_wb.sv
// tb_d16_alu_wb -- self-checking bench for d16_alu_wb.
// Honours D16_WB_SKID_EN the same way as the design (queue depth 1 or 2).
module tb_d16_alu_wb;
  import d16_pkg::*;

  localparam int REG_AW = 3;
`ifdef D16_WB_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [2:0] cond;
  logic [3:0] flags;
  logic       cond_true;

  d16_alu_wb_if #(.REG_AW(REG_AW)) bus ();

  d16_alu_wb #(.REG_AW(REG_AW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus),
    .flags     (flags),
    .cond      (cond),
    .cond_true (cond_true)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: a FIFO of pending writes, the status register and,
  // for the skid build, the registered ready.
  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
  } entry_t;

  entry_t     mdl_q[$];
  logic [3:0] mdl_flags = 4'b0000;
  bit         mdl_ready_reg = 1'b1;
  bit         last_dut_accept;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        vld;
    logic [2:0]  ctrl;
    logic [15:0] s;
    logic [3:0]  nozc;
    logic        wr;
    logic [2:0]  rd;
    logic [2:0]  cc;
    logic        e_wbv;
    logic [2:0]  e_addr;
    logic [15:0] e_data;
    logic [3:0]  e_flags;
    logic        e_ct;
  } vec_t;

  vec_t vecs[10];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit mdl_in_ready();
`ifdef D16_WB_SKID_EN
    return mdl_ready_reg;
`else
    return (mdl_q.size() == 0) || (bus.wb_ready == 1'b1);
`endif
  endfunction

  function automatic bit mdl_cond(input logic [2:0] cc, input logic [3:0] f);
    case (cc)
      3'd0: return 1'b1;
      3'd1: return f[1];
      3'd2: return !f[1];
      3'd3: return f[0];
      3'd4: return !f[0];
      3'd5: return f[3];
      3'd6: return f[2];
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle of inputs at the falling edge, advance the model at the
  // rising edge and leave the inputs held; returns 1 ns after the edge.
  task automatic applyStimulus(input logic vld, input logic [2:0] ctrl, input logic [15:0] s,
                               input logic [3:0] nozc, input logic wr, input logic [2:0] rd,
                               input logic wbr, input logic [2:0] cc);
    bit acc;
    bit drn;
    @(negedge sys_clk);
    bus.in_valid = vld;
    bus.ctrl_alu = ctrl;
    bus.s        = s;
    {bus.n, bus.o, bus.z, bus.c} = nozc;
    bus.wr_en    = wr;
    bus.rd       = rd;
    bus.wb_ready = wbr;
    cond         = cc;
    #1;
    acc = vld && mdl_in_ready();
    drn = (mdl_q.size() != 0) && wbr;
    last_dut_accept = vld && (bus.in_ready === 1'b1);
    @(posedge sys_clk);
    if (drn) void'(mdl_q.pop_front());
    if (acc && wr) mdl_q.push_back('{rd, s});
    if (acc && ctrl >= 3'd1 && ctrl <= 3'd4) mdl_flags = nozc;
    mdl_ready_reg = (mdl_q.size() < 2);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, mdl_in_ready()});
    checkVal({tag, ".wb_valid"}, {31'd0, bus.wb_valid}, {31'd0, mdl_q.size() != 0});
    if (mdl_q.size() != 0) begin
      checkVal({tag, ".wb_addr"}, {29'd0, bus.wb_addr}, {29'd0, mdl_q[0].addr});
      checkVal({tag, ".wb_data"}, {16'd0, bus.wb_data}, {16'd0, mdl_q[0].data});
    end
    checkVal({tag, ".flags"}, {28'd0, flags}, {28'd0, mdl_flags});
    checkVal({tag, ".cond_true"}, {31'd0, cond_true}, {31'd0, mdl_cond(cond, mdl_flags)});
  endtask

  logic [15:0] seq_data[3];
  int          accepted;

  initial begin
    // Expected behaviour with wb_ready=1 throughout, starting from reset.
    vecs[0] = '{1'b1, ALU_ADD, 16'h0000, 4'b0011, 1'b1, 3'd2, COND_Z,  1'b1, 3'd2, 16'h0000, 4'b0011, 1'b1};
    vecs[1] = '{1'b1, ALU_OR,  16'h00F0, 4'b1000, 1'b1, 3'd5, COND_N,  1'b1, 3'd5, 16'h00F0, 4'b0011, 1'b0};
    vecs[2] = '{1'b1, ALU_SUB, 16'h1234, 4'b0010, 1'b0, 3'd1, COND_Z,  1'b0, 3'd0, 16'h0000, 4'b0010, 1'b1};
    vecs[3] = '{1'b0, ALU_ADD, 16'hFFFF, 4'b1111, 1'b1, 3'd6, COND_AL, 1'b0, 3'd0, 16'h0000, 4'b0010, 1'b1};
    vecs[4] = '{1'b1, ALU_SHL, 16'h8000, 4'b0101, 1'b1, 3'd7, COND_C,  1'b1, 3'd7, 16'h8000, 4'b0101, 1'b1};
    vecs[5] = '{1'b1, ALU_NOP, 16'h1111, 4'b1111, 1'b1, 3'd3, COND_NC, 1'b1, 3'd3, 16'h1111, 4'b0101, 1'b0};
    vecs[6] = '{1'b1, ALU_SHR, 16'h0001, 4'b0000, 1'b1, 3'd4, COND_NZ, 1'b1, 3'd4, 16'h0001, 4'b0000, 1'b1};
    vecs[7] = '{1'b1, ALU_EQ,  16'h0000, 4'b0010, 1'b0, 3'd0, COND_NV, 1'b0, 3'd0, 16'h0000, 4'b0000, 1'b0};
    vecs[8] = '{1'b1, ALU_ADD, 16'hBEEF, 4'b1100, 1'b1, 3'd1, COND_O,  1'b1, 3'd1, 16'hBEEF, 4'b1100, 1'b1};
    vecs[9] = '{1'b0, ALU_NOP, 16'h0000, 4'b0000, 1'b0, 3'd0, COND_N,  1'b0, 3'd0, 16'h0000, 4'b1100, 1'b1};

    bus.in_valid = 1'b0;
    bus.ctrl_alu = ALU_NOP;
    bus.s        = 16'h0000;
    {bus.n, bus.o, bus.z, bus.c} = 4'b0000;
    bus.wr_en    = 1'b0;
    bus.rd       = '0;
    bus.wb_ready = 1'b1;
    cond         = COND_AL;

    // Reset values
    #2;
    checkVal("rst.wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    checkVal("rst.wb_addr", {29'd0, bus.wb_addr}, 32'd0);
    checkVal("rst.wb_data", {16'd0, bus.wb_data}, 32'd0);
    checkVal("rst.flags", {28'd0, flags}, 32'd0);
    checkVal("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkVal("rst.cond_al", {31'd0, cond_true}, 32'd1);
    cond = COND_Z;
    #1;
    checkVal("rst.cond_z", {31'd0, cond_true}, 32'd0);
    sys_rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].vld, vecs[i].ctrl, vecs[i].s, vecs[i].nozc, vecs[i].wr, vecs[i].rd,
                    1'b1, vecs[i].cc);
      checkVal({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      checkVal({tag, ".wb_valid"}, {31'd0, bus.wb_valid}, {31'd0, vecs[i].e_wbv});
      if (vecs[i].e_wbv) begin
        checkVal({tag, ".wb_addr"}, {29'd0, bus.wb_addr}, {29'd0, vecs[i].e_addr});
        checkVal({tag, ".wb_data"}, {16'd0, bus.wb_data}, {16'd0, vecs[i].e_data});
      end
      checkVal({tag, ".flags"}, {28'd0, flags}, {28'd0, vecs[i].e_flags});
      checkVal({tag, ".cond_true"}, {31'd0, cond_true}, {31'd0, vecs[i].e_ct});
      checkOutput({tag, ".mdl"});
    end

    // Stall: stream three ops with wb_ready=0, then release and drain in order
    seq_data[0] = 16'hA001;
    seq_data[1] = 16'hA002;
    seq_data[2] = 16'hA003;
    accepted = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      applyStimulus(1'b1, ALU_OR, seq_data[accepted], 4'b0000, 1'b1, accepted[2:0], 1'b0, COND_AL);
      checkOutput($sformatf("stall%0d", cyc));
      if (last_dut_accept) accepted++;
    end
    checkVal("stall.accepted", accepted, DEPTH);
    checkVal("stall.in_ready", {31'd0, bus.in_ready}, 32'd0);
    checkVal("stall.head", {16'd0, bus.wb_data}, {16'd0, seq_data[0]});
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, ALU_NOP, 16'h0000, 4'b0000, 1'b0, 3'd0, 1'b1, COND_AL);
      checkOutput($sformatf("drain%0d", i));
      if (i + 1 < DEPTH) begin
        checkVal($sformatf("drain%0d.wb_valid", i), {31'd0, bus.wb_valid}, 32'd1);
        checkVal($sformatf("drain%0d.wb_data", i), {16'd0, bus.wb_data}, {16'd0, seq_data[i+1]});
        checkVal($sformatf("drain%0d.wb_addr", i), {29'd0, bus.wb_addr}, i + 1);
      end else begin
        checkVal($sformatf("drain%0d.wb_valid", i), {31'd0, bus.wb_valid}, 32'd0);
      end
    end

    // Reset asserted mid-cycle with the queue full
    for (int cyc = 0; cyc < 3; cyc++) begin
      applyStimulus(1'b1, ALU_ADD, 16'h5A00 + 16'(cyc), 4'b1011, 1'b1, 3'd6, 1'b0, COND_AL);
      checkOutput($sformatf("fill%0d", cyc));
    end
    checkVal("fill.in_ready", {31'd0, bus.in_ready}, 32'd0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkVal("arst.wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    checkVal("arst.flags", {28'd0, flags}, 32'd0);
    checkVal("arst.wb_data", {16'd0, bus.wb_data}, 32'd0);
    checkVal("arst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkVal("arst.cond_true", {31'd0, cond_true}, 32'd1);
    mdl_q.delete();
    mdl_flags = 4'b0000;
    mdl_ready_reg = 1'b1;
    sys_rst_n = 1'b1;
    #0.5;
    checkVal("arst.rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
    applyStimulus(1'b1, ALU_SUB, 16'h0C0D, 4'b0100, 1'b1, 3'd5, 1'b1, COND_O);
    checkVal("arst.first.wb_valid", {31'd0, bus.wb_valid}, 32'd1);
    checkVal("arst.first.wb_data", {16'd0, bus.wb_data}, 32'h0C0D);
    checkVal("arst.first.flags", {28'd0, flags}, 32'h4);
    checkOutput("arst.first");

    // Back-to-back ops with wb_ready=1: a writeback every cycle
    for (int i = 0; i < 8; i++) begin
      logic [15:0] d;
      d = 16'(16'h3000 + i);
      applyStimulus(1'b1, (i % 2 == 0) ? ALU_ADD : ALU_SUB, d, 4'(i), 1'b1, 3'(i), 1'b1, 3'(i));
      checkVal($sformatf("b2b%0d.wb_valid", i), {31'd0, bus.wb_valid}, 32'd1);
      checkVal($sformatf("b2b%0d.wb_data", i), {16'd0, bus.wb_data}, {16'd0, d});
      checkVal($sformatf("b2b%0d.flags", i), {28'd0, flags}, i);
      checkOutput($sformatf("b2b%0d", i));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
                    4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)));
      checkOutput($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/d16_alu_wb.md
# d16_alu_wb

Writeback stage directly downstream of the d16 ALU. It captures the ALU result and its combinational n/o/z/c flags on a valid/ready handshake and maintains the architectural status register. It buffers the result and presents it to the register-file write port, and evaluates branch conditions against the status register. It isolates the ALU's purely combinational outputs from register-file back-pressure.

## Interface
- REG_AW, 3, register-file address width
- sys_clk  in  1  system clock, all state on rising edge
- sys_rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  ALU operands/ctrl stable, result valid this cycle
- in_ready  out  1  stage can accept this cycle
- ctrl_alu  in  3  ALU opcode of the offered op
- s  in  16  ALU result
- n, o, z, c  in  1 each  ALU flags
- wr_en  in  1  op writes s to register file
- rd  in  REG_AW  destination register
- wb_valid  out  1  writeback entry pending
- wb_ready  in  1  register file accepts entry this cycle
- wb_addr  out  REG_AW  destination of head entry
- wb_data  out  16  data of head entry
- flags  out  4  status register {n,o,z,c}
- cond  in  3  branch condition code
- cond_true  out  1  cond evaluated on flags

## Operation
- Accept = in_valid & in_ready. Inputs are sampled only on accept.
- Flag update on accept iff ctrl_alu in 001..100 (add, sub, shl, shr): flags <= {n,o,z,c}. Opcodes 000 and 101..111 leave flags unchanged.
- Flags update at accept time, not at drain, so they reflect program order regardless of writeback stalls.
- Enqueue on accept iff wr_en=1: entry {rd, s}. Accept with wr_en=0 consumes the op without enqueue (flag rule still applies).
- Drain = wb_valid & wb_ready. Head entry retires and the next entry (if any) becomes head. Order is FIFO.
- Simultaneous accept+enqueue and drain is legal; occupancy is unchanged.
- cond codes:
  - 000 always
  - 001 z
  - 010 !z
  - 011 c
  - 100 !c
  - 101 n
  - 110 o
  - 111 never
- cond_true is combinational from cond and the flags register. It does not see an update accepted in the same cycle.
- wb_addr/wb_data hold stable while wb_valid=1 and wb_ready=0.

## Timing
- Reset values:
  - wb_valid=0
  - wb_addr=0
  - wb_data=0
  - flags=4'b0000
  - cond_true=(cond==000)
  - in_ready=1
- Reset flushes all buffered entries immediately, including mid-stall. The first accept is possible in the first clock after deassertion.
- Latency: op accepted in cycle t gives wb_valid=1 and flags updated in cycle t+1.
- Throughput: one op per cycle while wb_ready=1.
- Full: in_ready=0. Ops offered while full are not accepted, and flags do not change.
- Empty with no enqueue: wb_valid stays 0.

## Configuration
- D16_WB_SKID_EN defined:
  - Two-entry skid buffer.
  - in_ready is a register, =1 iff occupancy<2 after this cycle's updates. No combinational path from wb_ready to in_ready.
  - Full throughput is sustained across a one-cycle wb_ready drop.
- Undefined:
  - Single entry.
  - in_ready = ~wb_valid | wb_ready, which is a combinational path from wb_ready.
  - A stall blocks the upstream ALU in the same cycle.

## Structure
- Shared package d16_pkg holds:
  - ALU opcode constants (ALU_NOP=000 … ALU_EQ=111)
  - condition-code constants
  - flag bit indices (FLAG_N=3, FLAG_O=2, FLAG_Z=1, FLAG_C=0)
- Sub-module d16_skid_buf (data width parameter, depth 1 or 2 per macro) holds the writeback queue.
- The status register and condition logic live in the top.

## Test plan
- Reset, then offer add s=16'h0000 z=1 c=1 wr_en=1 rd=2:
  - cycle after: wb_valid=1, wb_addr=2, wb_data=0, flags=4'b0011
  - cond=001 gives cond_true=1
- Offer or (ctrl=101) s=16'h00F0, n=1, wr_en=1 after flags=0011: flags stay 0011 and the entry is written.
- Hold wb_ready=0 and stream three ops:
  - with macro, two accepted then in_ready=0
  - without macro, one accepted
  - release: entries drain in order, one per cycle
- Accept sub with wr_en=0 z=1: flags=0010, wb_valid stays 0.
- Queue full, assert sys_rst_n=0 asynchronously mid-cycle: wb_valid=0 and flags=0 without waiting for a clock edge. After release, in_ready=1.
- Continuous ops with wb_ready=1: one writeback per cycle, back-to-back, no bubbles, and flags track each arithmetic op one cycle later.
